// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: shares the single L2 CPU-side port between the I-cache and
// D-cache pmem ports. Whole-line transactions are serialised; every grant is
// followed by one dead GAP cycle so an owner can drop a finished request
// before arbitration looks at it again.
module l2_mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int LINE_W     = 128,
   parameter int D_PRIORITY = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp,
   output logic              arb_busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      GAP    = 2'd3
   } state_t;

   state_t            state;
   state_t            next_state;
   logic              last_grant;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic              write_q;
   logic              req_i;
   logic              req_d;
   logic              grant_any;
   logic              grant_d;

   // Decide who would win if arbitration happened this cycle (last_grant: 0 = I, 1 = D)
   always_comb begin
      req_i     = i_read;
      req_d     = d_read | d_write;
      grant_any = req_i | req_d;
      grant_d   = 1'b0;
      if (req_d && !req_i) begin
         grant_d = 1'b1;
      end else if (req_d && req_i) begin
         grant_d = (D_PRIORITY != 0) ? 1'b1 : ~last_grant;
      end
   end

   // Next-state logic: grant only from IDLE, finish on l2_resp, always one GAP cycle
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (grant_any) begin
               next_state = grant_d ? BUSY_D : BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (l2_resp) begin
               next_state = GAP;
            end
         end
         GAP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register; reset abandons any in-flight L2 transaction
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Capture the winning request so the L2 sees stable values even if the owner changes its inputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         last_grant <= 1'b0;
      end else if (state == IDLE && grant_any) begin
         addr_q     <= grant_d ? d_addr : i_addr;
         write_q    <= grant_d & d_write;
         last_grant <= grant_d;
         if (grant_d) begin
            wdata_q <= d_wdata;
         end
      end
   end

   // L2-side drive and response steering, all from state and latched registers
   always_comb begin
      l2_read  = 1'b0;
      l2_write = 1'b0;
      l2_addr  = '0;
      l2_wdata = '0;
      i_resp   = 1'b0;
      d_resp   = 1'b0;
      arb_busy = (state != IDLE);
      case (state)
         BUSY_I: begin
            l2_read = 1'b1;
            l2_addr = addr_q;
            i_resp  = l2_resp;
         end
         BUSY_D: begin
            l2_read  = ~write_q;
            l2_write = write_q;
            l2_addr  = addr_q;
            l2_wdata = write_q ? wdata_q : '0;
            d_resp   = l2_resp;
         end
         default: begin
            l2_read = 1'b0;
         end
      endcase
   end

   assign i_rdata = l2_rdata;
   assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb_l2_mem_arbiter: drives one round-robin and one D-priority arbiter with the
// same cache-side requests. A transaction-level model predicts both every cycle;
// directed literal checks pin the key timing and ordering cases.
module tb_l2_mem_arbiter;

   logic         clk;
   logic         reset_n;
   logic         i_read;
   logic         d_read;
   logic         d_write;
   logic [15:0]  i_addr;
   logic [15:0]  d_addr;
   logic [127:0] d_wdata;
   logic [127:0] l2_rdata;
   logic         man_resp;
   logic         rr_auto;
   logic         auto_rr;
   logic         auto_pr;
   logic         l2_resp_rr;
   logic         l2_resp_pr;
   int           cnt_rr;
   int           cnt_pr;

   logic [127:0] rr_i_rdata, rr_d_rdata, rr_l2_wdata;
   logic [15:0]  rr_l2_addr;
   logic         rr_i_resp, rr_d_resp, rr_l2_read, rr_l2_write, rr_arb_busy;
   logic [127:0] pr_i_rdata, pr_d_rdata, pr_l2_wdata;
   logic [15:0]  pr_l2_addr;
   logic         pr_i_resp, pr_d_resp, pr_l2_read, pr_l2_write, pr_arb_busy;

   int checks = 0;
   int errors = 0;

   // transaction-level model, index 0 = round-robin DUT, 1 = D-priority DUT
   logic         m_act[2];
   logic         m_own_d[2];
   logic         m_wr[2];
   logic [15:0]  m_addr[2];
   logic [127:0] m_wdata[2];
   int           m_gap[2];
   logic         m_last_d[2];

   logic [15:0]  rr_q[$];
   logic [15:0]  pr_q[$];
   logic         prev_rr;
   logic         prev_pr;

   localparam logic [127:0] WB1 = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_BEEF;
   localparam logic [127:0] WB2 = 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004;
   localparam logic [127:0] RD1 = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;

   assign l2_resp_rr = rr_auto ? auto_rr : man_resp;
   assign l2_resp_pr = auto_pr;

   l2_mem_arbiter #(.ADDR_W(16), .LINE_W(128), .D_PRIORITY(0)) dut_rr (
      .clk(clk), .reset_n(reset_n),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(rr_i_rdata), .i_resp(rr_i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(rr_d_rdata), .d_resp(rr_d_resp),
      .l2_read(rr_l2_read), .l2_write(rr_l2_write), .l2_addr(rr_l2_addr),
      .l2_wdata(rr_l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp_rr),
      .arb_busy(rr_arb_busy)
   );

   l2_mem_arbiter #(.ADDR_W(16), .LINE_W(128), .D_PRIORITY(1)) dut_pr (
      .clk(clk), .reset_n(reset_n),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(pr_i_rdata), .i_resp(pr_i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(pr_d_rdata), .d_resp(pr_d_resp),
      .l2_read(pr_l2_read), .l2_write(pr_l2_write), .l2_addr(pr_l2_addr),
      .l2_wdata(pr_l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp_pr),
      .arb_busy(pr_arb_busy)
   );

   // free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // stand-in L2 for the round-robin DUT when auto mode is on: answers in the third busy cycle
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         auto_rr <= 1'b0;
         cnt_rr  <= 0;
      end else if (!rr_auto || auto_rr) begin
         auto_rr <= 1'b0;
         cnt_rr  <= 0;
      end else if (rr_l2_read || rr_l2_write) begin
         if (cnt_rr == 1) auto_rr <= 1'b1;
         else cnt_rr <= cnt_rr + 1;
      end
   end

   // stand-in L2 for the D-priority DUT, always answering in the fourth busy cycle
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         auto_pr <= 1'b0;
         cnt_pr  <= 0;
      end else if (auto_pr) begin
         auto_pr <= 1'b0;
         cnt_pr  <= 0;
      end else if (pr_l2_read || pr_l2_write) begin
         if (cnt_pr == 2) auto_pr <= 1'b1;
         else cnt_pr <= cnt_pr + 1;
      end
   end

   // who the arbitration rules say wins right now for arbiter k
   function automatic logic pickD(input int k);
      logic want_d;
      want_d = d_read || d_write;
      if (want_d && i_read) return (k == 1) ? 1'b1 : !m_last_d[k];
      return want_d;
   endfunction

   // model: a transaction is open until its L2 response, then one idle slot, then a new grant
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 2; k++) begin
            m_act[k]    <= 1'b0;
            m_own_d[k]  <= 1'b0;
            m_wr[k]     <= 1'b0;
            m_addr[k]   <= '0;
            m_wdata[k]  <= '0;
            m_gap[k]    <= 0;
            m_last_d[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_act[k]) begin
               if ((k == 0) ? l2_resp_rr : l2_resp_pr) begin
                  m_act[k] <= 1'b0;
                  m_gap[k] <= 1;
               end
            end else if (m_gap[k] > 0) begin
               m_gap[k] <= m_gap[k] - 1;
            end else if (i_read || d_read || d_write) begin
               m_act[k]    <= 1'b1;
               m_own_d[k]  <= pickD(k);
               m_wr[k]     <= pickD(k) && d_write;
               m_addr[k]   <= pickD(k) ? d_addr : i_addr;
               m_last_d[k] <= pickD(k);
               if (pickD(k)) m_wdata[k] <= d_wdata;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic cmpDut(input int k, input string p, input logic rd, input logic wr,
                         input logic [15:0] ad, input logic [127:0] wd, input logic ir,
                         input logic dr, input logic bz, input logic [127:0] ird,
                         input logic [127:0] drd, input logic rsp);
      checkOutput({p, ".l2_read"},  128'(rd), 128'(m_act[k] && !m_wr[k]));
      checkOutput({p, ".l2_write"}, 128'(wr), 128'(m_act[k] && m_wr[k]));
      checkOutput({p, ".l2_addr"},  128'(ad), 128'(m_act[k] ? m_addr[k] : 16'h0));
      checkOutput({p, ".l2_wdata"}, wd, (m_act[k] && m_wr[k]) ? m_wdata[k] : 128'h0);
      checkOutput({p, ".i_resp"},   128'(ir), 128'(m_act[k] && !m_own_d[k] && rsp));
      checkOutput({p, ".d_resp"},   128'(dr), 128'(m_act[k] && m_own_d[k] && rsp));
      checkOutput({p, ".arb_busy"}, 128'(bz), 128'(m_act[k] || (m_gap[k] > 0)));
      checkOutput({p, ".i_rdata"},  ird, l2_rdata);
      checkOutput({p, ".d_rdata"},  drd, l2_rdata);
   endtask

   task automatic compareCycle();
      cmpDut(0, "rr", rr_l2_read, rr_l2_write, rr_l2_addr, rr_l2_wdata, rr_i_resp,
             rr_d_resp, rr_arb_busy, rr_i_rdata, rr_d_rdata, l2_resp_rr);
      cmpDut(1, "pr", pr_l2_read, pr_l2_write, pr_l2_addr, pr_l2_wdata, pr_i_resp,
             pr_d_resp, pr_arb_busy, pr_i_rdata, pr_d_rdata, l2_resp_pr);
   endtask

   task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic dr,
                                input logic dw, input logic [15:0] da,
                                input logic [127:0] dwd);
      i_read  = ir;
      i_addr  = ia;
      d_read  = dr;
      d_write = dw;
      d_addr  = da;
      d_wdata = dwd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] rr_exp[4];

   initial begin
      reset_n  = 1'b0;
      man_resp = 1'b0;
      rr_auto  = 1'b0;
      l2_rdata = '0;
      prev_rr  = 1'b0;
      prev_pr  = 1'b0;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
      rr_exp[0] = 16'h2000;
      rr_exp[1] = 16'h1000;
      rr_exp[2] = 16'h2000;
      rr_exp[3] = 16'h1000;

      fork
         forever begin
            @(negedge clk);
            compareCycle();
         end
      join_none

      // reset state
      tick();
      tick();
      checkOutput("reset.l2_read",  128'(rr_l2_read),  128'(0));
      checkOutput("reset.l2_write", 128'(rr_l2_write), 128'(0));
      checkOutput("reset.l2_addr",  128'(rr_l2_addr),  128'(0));
      checkOutput("reset.arb_busy", 128'(rr_arb_busy), 128'(0));
      reset_n = 1'b1;

      // I-cache read: request cycle 1, L2 request cycle 2, resp cycle 5, idle cycle 7
      tick();
      applyStimulus(1'b1, 16'h3000, 1'b0, 1'b0, 16'h0, '0);
      checkOutput("t1.c1.arb_busy", 128'(rr_arb_busy), 128'(0));
      tick();
      checkOutput("t1.c2.l2_read",  128'(rr_l2_read), 128'(1));
      checkOutput("t1.c2.l2_addr",  128'(rr_l2_addr), 128'(16'h3000));
      tick();
      checkOutput("t1.c3.i_resp", 128'(rr_i_resp), 128'(0));
      tick();
      tick();
      man_resp = 1'b1;
      l2_rdata = RD1;
      #1;
      checkOutput("t1.c5.i_resp",  128'(rr_i_resp), 128'(1));
      checkOutput("t1.c5.d_resp",  128'(rr_d_resp), 128'(0));
      checkOutput("t1.c5.i_rdata", rr_i_rdata, RD1);
      tick();
      man_resp = 1'b0;
      applyStimulus(1'b0, 16'h3000, 1'b0, 1'b0, 16'h0, '0);
      #1;
      checkOutput("t1.c6.i_resp",   128'(rr_i_resp),   128'(0));
      checkOutput("t1.c6.arb_busy", 128'(rr_arb_busy), 128'(1));
      tick();
      checkOutput("t1.c7.arb_busy", 128'(rr_arb_busy), 128'(0));

      // D writeback held through a 10-cycle L2 stall while live inputs change
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h4010, WB1);
      tick();
      checkOutput("t2.l2_write", 128'(rr_l2_write), 128'(1));
      checkOutput("t2.l2_read",  128'(rr_l2_read),  128'(0));
      checkOutput("t2.l2_addr",  128'(rr_l2_addr),  128'(16'h4010));
      checkOutput("t2.l2_wdata", rr_l2_wdata, WB1);
      d_addr  = 16'h0BAD;
      d_wdata = ~WB1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checkOutput("t2.stall.l2_addr",  128'(rr_l2_addr), 128'(16'h4010));
         checkOutput("t2.stall.l2_wdata", rr_l2_wdata, WB1);
         checkOutput("t2.stall.d_resp",   128'(rr_d_resp), 128'(0));
      end
      man_resp = 1'b1;
      #1;
      checkOutput("t2.d_resp", 128'(rr_d_resp), 128'(1));
      checkOutput("t2.i_resp", 128'(rr_i_resp), 128'(0));
      tick();
      man_resp = 1'b0;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
      #1;
      checkOutput("t2.d_resp_once", 128'(rr_d_resp), 128'(0));
      tick();
      tick();

      // both requesters held: round-robin alternates D,I,D,I; priority always D
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      rr_auto = 1'b1;
      applyStimulus(1'b1, 16'h1000, 1'b1, 1'b0, 16'h2000, '0);
      for (int c = 0; c < 40; c++) begin
         tick();
         if (rr_l2_read && !prev_rr) rr_q.push_back(rr_l2_addr);
         if (pr_l2_read && !prev_pr) pr_q.push_back(pr_l2_addr);
         prev_rr = rr_l2_read;
         prev_pr = pr_l2_read;
      end
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
      repeat (10) tick();
      rr_auto = 1'b0;
      checkOutput("t3.rr_count", 128'(rr_q.size() >= 4), 128'(1));
      checkOutput("t3.pr_count", 128'(pr_q.size() >= 4), 128'(1));
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("t3.rr_grant%0d", i),
                     128'((i < rr_q.size()) ? rr_q[i] : 16'h0), 128'(rr_exp[i]));
         checkOutput($sformatf("t3.pr_grant%0d", i),
                     128'((i < pr_q.size()) ? pr_q[i] : 16'h0), 128'(16'h2000));
      end

      // I request dropped right after grant with a new address: latched op still completes
      applyStimulus(1'b1, 16'h5A00, 1'b0, 1'b0, 16'h0, '0);
      tick();
      checkOutput("t4.l2_read", 128'(rr_l2_read), 128'(1));
      tick();
      applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0, '0);
      repeat (3) begin
         tick();
         checkOutput("t4.l2_addr", 128'(rr_l2_addr), 128'(16'h5A00));
         checkOutput("t4.l2_read_held", 128'(rr_l2_read), 128'(1));
      end
      man_resp = 1'b1;
      #1;
      checkOutput("t4.i_resp", 128'(rr_i_resp), 128'(1));
      tick();
      man_resp = 1'b0;
      tick();
      tick();

      // asynchronous reset in the middle of a D writeback
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h7770, WB2);
      tick();
      checkOutput("t5.l2_write", 128'(rr_l2_write), 128'(1));
      tick();
      man_resp = 1'b1;
      #1;
      checkOutput("t5.d_resp_pre", 128'(rr_d_resp), 128'(1));
      #1;
      reset_n = 1'b0;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
      #1;
      checkOutput("t5.async.l2_write", 128'(rr_l2_write), 128'(0));
      checkOutput("t5.async.d_resp",   128'(rr_d_resp),   128'(0));
      checkOutput("t5.async.arb_busy", 128'(rr_arb_busy), 128'(0));
      checkOutput("t5.async.l2_addr",  128'(rr_l2_addr),  128'(0));
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      checkOutput("t5.late.d_resp", 128'(rr_d_resp), 128'(0));
      checkOutput("t5.late.i_resp", 128'(rr_i_resp), 128'(0));
      man_resp = 1'b0;
      tick();

      // illegal read+write counts as write; spurious l2_resp in GAP and IDLE is ignored
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0ABC, WB2);
      tick();
      checkOutput("t6.l2_write", 128'(rr_l2_write), 128'(1));
      checkOutput("t6.l2_read",  128'(rr_l2_read),  128'(0));
      checkOutput("t6.l2_wdata", rr_l2_wdata, WB2);
      tick();
      man_resp = 1'b1;
      #1;
      checkOutput("t6.d_resp", 128'(rr_d_resp), 128'(1));
      tick();
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
      #1;
      checkOutput("t6.gap.d_resp",   128'(rr_d_resp),   128'(0));
      checkOutput("t6.gap.arb_busy", 128'(rr_arb_busy), 128'(1));
      tick();
      checkOutput("t6.idle.d_resp",   128'(rr_d_resp),   128'(0));
      checkOutput("t6.idle.i_resp",   128'(rr_i_resp),   128'(0));
      checkOutput("t6.idle.arb_busy", 128'(rr_arb_busy), 128'(0));
      tick();
      man_resp = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
